// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller.
package uart_rx_pkg;

    // Frame controller states, binary encoded
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_DATA     = 3'd2,
        ST_PARITY   = 3'd3,
        ST_STOP     = 3'd4,
        ST_BRK_WAIT = 3'd5
    } rx_state_t;

    // par_mode encodings; 2'b11 also behaves as no parity
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Supported oversampling ratios
    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    // Data length used when the requested one is out of range
    localparam logic [3:0] DATA_LEN_DEFAULT = 4'd8;

    // Maps a requested oversampling ratio onto a supported one (fallback 8)
    function automatic logic [5:0] decode_prescale(input int unsigned p);
        if (p == PRESCALE_16) return 6'(PRESCALE_16);
        if (p == PRESCALE_32) return 6'(PRESCALE_32);
        return 6'(PRESCALE_8);
    endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// Received-frame handshake between the frame controller and its consumer.
interface uart_rx_frame_ctrl_if #(
    parameter int unsigned DATA_W_MAX = 9
);
    logic [DATA_W_MAX-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  par_err;
    logic                  frm_err;

    modport master (output rx_data, output rx_valid, output par_err, output frm_err,
                    input  rx_ready);
    modport slave  (input  rx_data, input  rx_valid, input  par_err, input  frm_err,
                    output rx_ready);
endinterface

// File: rtl/uart_rx_majority_sampler.sv
// Three-sample capture around mid-bit with a registered 2-of-3 vote.
module uart_rx_majority_sampler (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] edge_cnt,
    input  logic [5:0] prescale,
    input  logic       RX_IN,
    output logic       vote,
    output logic       vote_vld
);

    logic [5:0] half;
    logic       s0;
    logic       s1;

    assign half = prescale >> 1;

    // Capture samples at P/2-1 and P/2, vote with the P/2+1 sample
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s0       <= 1'b0;
            s1       <= 1'b0;
            vote     <= 1'b0;
            vote_vld <= 1'b0;
        end else begin
            vote_vld <= 1'b0;
            if (edge_cnt == half - 6'd1) s0 <= RX_IN;
            if (edge_cnt == half)        s1 <= RX_IN;
            if (edge_cnt == half + 6'd1) begin
                vote     <= (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
                vote_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: run-time configurable framing, break and
// overrun detection, valid/ready delivery of received words.
module uart_rx_frame_ctrl
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_W_MAX = 9,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic [3:0]            data_len,
    input  logic [1:0]            par_mode,
    input  logic                  two_stop,
    uart_rx_frame_ctrl_if.master  rx_if,
    output logic                  brk_det,
    output logic                  ovr_err,
    output logic                  busy
);

    rx_state_t             state, next_state;
    logic [5:0]            edge_cnt, p_lat;
    logic [3:0]            bit_cnt, dlen_lat, dlen_dec;
    logic [1:0]            pmode_lat;
    logic                  two_stop_lat, stop_cnt;
    logic [DATA_W_MAX-1:0] shreg;
    logic                  all_zero, par_bad, frm_bad;
    logic                  vote, vote_vld;
    logic                  bit_end, last_data, last_stop, par_en, start_det;
    logic                  frame_end, brk_hit;

    assign dlen_dec  = (data_len >= 4'd5 && 32'(data_len) <= DATA_W_MAX) ? data_len
                                                                         : DATA_LEN_DEFAULT;
    assign bit_end   = (edge_cnt == p_lat - 6'd1);
    assign last_data = (bit_cnt == dlen_lat - 4'd1);
    assign last_stop = (stop_cnt == two_stop_lat);
    assign par_en    = (pmode_lat == PAR_EVEN) || (pmode_lat == PAR_ODD);
    assign start_det = (state == ST_IDLE) && !RX_IN;
    assign busy      = (state != ST_IDLE);

    uart_rx_majority_sampler u_sampler (
        .CLK      (CLK),
        .RST      (RST),
        .edge_cnt (edge_cnt),
        .prescale (p_lat),
        .RX_IN    (RX_IN),
        .vote     (vote),
        .vote_vld (vote_vld)
    );

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic plus frame-end and break strobes
    always_comb begin
        next_state = state;
        frame_end  = 1'b0;
        brk_hit    = 1'b0;
        case (state)
            ST_IDLE:     if (!RX_IN) next_state = ST_START;
            ST_START: begin
                if (vote_vld && vote) next_state = ST_IDLE;
                else if (bit_end)     next_state = ST_DATA;
            end
            ST_DATA:     if (bit_end && last_data) next_state = par_en ? ST_PARITY : ST_STOP;
            ST_PARITY:   if (bit_end) next_state = ST_STOP;
            ST_STOP: begin
                // The held vote at P-1 is this stop bit's vote
                if (bit_end) begin
                    if (!stop_cnt && all_zero && !vote) begin
                        brk_hit    = 1'b1;
                        next_state = ST_BRK_WAIT;
                    end else if (last_stop) begin
                        frame_end  = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            ST_BRK_WAIT: if (RX_IN) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Config latch, bit timing counters, deserialiser and error accumulation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            p_lat        <= '0;
            dlen_lat     <= '0;
            pmode_lat    <= '0;
            two_stop_lat <= 1'b0;
            shreg        <= '0;
            all_zero     <= 1'b0;
            par_bad      <= 1'b0;
            frm_bad      <= 1'b0;
        end else if (start_det) begin
            // Detection cycle is edge 0, so the first START cycle is edge 1
            edge_cnt     <= 6'd1;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            p_lat        <= decode_prescale(32'(Prescale));
            dlen_lat     <= dlen_dec;
            pmode_lat    <= par_mode;
            two_stop_lat <= two_stop;
            shreg        <= '0;
            all_zero     <= 1'b1;
            par_bad      <= 1'b0;
            frm_bad      <= 1'b0;
        end else if (next_state == ST_IDLE || next_state == ST_BRK_WAIT) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
            case (state)
                ST_DATA: begin
                    if (vote_vld) begin
                        shreg[bit_cnt] <= vote;
                        if (vote) all_zero <= 1'b0;
                    end
                    if (bit_end) bit_cnt <= bit_cnt + 4'd1;
                end
                ST_PARITY: begin
                    if (vote_vld) begin
                        if (vote) all_zero <= 1'b0;
                        par_bad <= (pmode_lat == PAR_ODD) ? ~(^shreg ^ vote) : (^shreg ^ vote);
                    end
                end
                ST_STOP: begin
                    if (vote_vld && !vote) frm_bad <= 1'b1;
                    if (bit_end) stop_cnt <= stop_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Output holding register, handshake and one-cycle event pulses
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
            rx_if.par_err  <= 1'b0;
            rx_if.frm_err  <= 1'b0;
            brk_det        <= 1'b0;
            ovr_err        <= 1'b0;
        end else begin
            brk_det <= brk_hit;
            ovr_err <= 1'b0;
            if (rx_if.rx_valid && rx_if.rx_ready) rx_if.rx_valid <= 1'b0;
            if (frame_end) begin
                if (!rx_if.rx_valid || rx_if.rx_ready) begin
                    rx_if.rx_data  <= shreg;
                    rx_if.par_err  <= par_bad;
                    rx_if.frm_err  <= frm_bad;
                    rx_if.rx_valid <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: frame-level reference model
// plus directed literal checks.
module tb_uart_rx_frame_ctrl;
    import uart_rx_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic [3:0] data_len = 4'd8;
    logic [1:0] par_mode = 2'b00;
    logic       two_stop = 1'b0;
    logic       brk_det, ovr_err, busy;
    logic       rdy = 1'b0;
    logic       started = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int brk_cnt = 0;

    typedef struct {
        int         at;
        bit         brk;
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } ev_t;
    ev_t evq[$];

    logic       m_valid = 1'b0;
    logic [8:0] m_data = '0;
    logic       m_pe = 1'b0;
    logic       m_fe = 1'b0;
    logic       m_brk = 1'b0;
    logic       m_ovr = 1'b0;

    uart_rx_frame_ctrl_if #(.DATA_W_MAX(9)) rx_if ();
    assign rx_if.rx_ready = rdy;

    uart_rx_frame_ctrl #(.DATA_W_MAX(9), .PRESCALE_W(6)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .RX_IN    (RX_IN),
        .Prescale (Prescale),
        .data_len (data_len),
        .par_mode (par_mode),
        .two_stop (two_stop),
        .rx_if    (rx_if),
        .brk_det  (brk_det),
        .ovr_err  (ovr_err),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk9(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame outcomes scheduled by the driver, delivery rules applied per edge
    always @(posedge CLK) begin
        ev_t e;
        bit  hit;
        cyc++;
        m_brk = 1'b0;
        m_ovr = 1'b0;
        hit   = 0;
        if (RST) begin
            m_valid = 1'b0; m_data = '0; m_pe = 1'b0; m_fe = 1'b0;
            evq.delete();
        end else begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
                e = evq.pop_front();
                if (e.brk) m_brk = 1'b1;
                else begin
                    hit = 1;
                    if (!m_valid || rdy) begin
                        m_valid = 1'b1; m_data = e.data; m_pe = e.pe; m_fe = e.fe;
                    end else m_ovr = 1'b1;
                end
            end
            if (!hit && m_valid && rdy) m_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge CLK) begin
        if (!RST && started) begin
            chk1("rx_valid", rx_if.rx_valid, m_valid);
            chk1("brk_det", brk_det, m_brk);
            chk1("ovr_err", ovr_err, m_ovr);
            if (m_valid) begin
                chk9("rx_data", rx_if.rx_data, m_data);
                chk1("par_err", rx_if.par_err, m_pe);
                chk1("frm_err", rx_if.frm_err, m_fe);
            end
        end
        if (brk_det === 1'b1) brk_cnt++;
    end

    function automatic int eff_p(input logic [5:0] pr);
        if (pr == 6'd16) return 16;
        if (pr == 6'd32) return 32;
        return 8;
    endfunction

    function automatic int eff_n(input logic [3:0] dl);
        if (dl >= 4'd5 && dl <= 4'd9) return int'(dl);
        return 8;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic drive_bit(input logic v, input int p, input int g);
        for (int j = 0; j < p; j++) begin
            RX_IN = (j == g) ? ~v : v;
            @(posedge CLK); #1;
        end
    endtask

    // Sends one frame; glitch_bit inverts the middle sample of that data bit
    task automatic send_frame(input logic [5:0] presc, input logic [3:0] dlen, input logic [1:0] pm,
                              input logic ts, input logic [8:0] data, input bit bad_par,
                              input logic stop0, input int glitch_bit, input int extra_low);
        int p, n, k, pn, len;
        logic [8:0] d, mask;
        logic pbit, pe, fe, isbrk;
        ev_t e;
        Prescale = presc; data_len = dlen; par_mode = pm; two_stop = ts;
        p    = eff_p(presc);
        n    = eff_n(dlen);
        pn   = (pm == 2'b01 || pm == 2'b10) ? 1 : 0;
        mask = (9'd1 << n) - 9'd1;
        d    = data & mask;
        pbit = (pm == 2'b10) ? ~(^d) : (^d);
        if (bad_par) pbit = ~pbit;
        pe    = (pn == 1) && ((pm == 2'b01) ? (^d ^ pbit) : ~(^d ^ pbit));
        fe    = ~stop0;
        isbrk = (d == 9'd0) && (pn == 0 || pbit == 1'b0) && (stop0 == 1'b0);
        len   = 1 + n + pn + 1 + (ts ? 1 : 0);
        k     = cyc;
        if (isbrk) e = '{at: k + (2 + n + pn) * p, brk: 1'b1, data: '0, pe: 1'b0, fe: 1'b0};
        else       e = '{at: k + len * p, brk: 1'b0, data: d, pe: pe, fe: fe};
        evq.push_back(e);
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < n; i++) drive_bit(d[i], p, (i == glitch_bit) ? p / 2 : -1);
        if (pn == 1) drive_bit(pbit, p, -1);
        drive_bit(stop0, p, -1);
        if (ts) drive_bit(1'b1, p, -1);
        repeat (extra_low) begin RX_IN = 1'b0; @(posedge CLK); #1; end
        RX_IN = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk1("rst_valid", rx_if.rx_valid, 1'b0);
        chk9("rst_data", rx_if.rx_data, 9'h000);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_brk", brk_det, 1'b0);
        chk1("rst_ovr", ovr_err, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0; rdy = 1'b1; started = 1'b1;
        idle(4);

        // 8N1, P=8, 0xA5: valid 80 cycles after detection
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h0A5, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk1("a5_valid", rx_if.rx_valid, 1'b1);
        chk9("a5_data", rx_if.rx_data, 9'h0A5);
        chk1("a5_par", rx_if.par_err, 1'b0);
        chk1("a5_frm", rx_if.frm_err, 1'b0);
        chk1("a5_busy", busy, 1'b0);
        @(posedge CLK); #1;

        // 7O2, P=16, 0x41 with wrong parity bit: 176-cycle frame
        send_frame(6'd16, 4'd7, 2'b10, 1'b1, 9'h041, 1, 1'b1, -1, 0);
        @(negedge CLK);
        chk1("o7_valid", rx_if.rx_valid, 1'b1);
        chk9("o7_data", rx_if.rx_data, 9'h041);
        chk1("o7_par", rx_if.par_err, 1'b1);
        @(posedge CLK); #1;

        // Short low pulse at P=16 is rejected at the start vote
        Prescale = 6'd16;
        RX_IN = 1'b0; idle(3); RX_IN = 1'b1;
        idle(3);
        @(negedge CLK);
        chk1("glitch_busy_mid", busy, 1'b1);
        @(posedge CLK); #1;
        idle(20);
        @(negedge CLK);
        chk1("glitch_busy_end", busy, 1'b0);
        chk1("glitch_valid", rx_if.rx_valid, 1'b0);
        @(posedge CLK); #1;

        // 8E1, P=16, 0x96 received after the rejected start
        send_frame(6'd16, 4'd8, 2'b01, 1'b0, 9'h096, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk9("e8_data", rx_if.rx_data, 9'h096);
        chk1("e8_par", rx_if.par_err, 1'b0);
        @(posedge CLK); #1;

        // Mid-sample glitch on data bit 3 is voted out
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h055, 0, 1'b1, 3, 0);
        @(negedge CLK);
        chk9("vote_data", rx_if.rx_data, 9'h055);
        @(posedge CLK); #1;

        // Line low for 12 bit-times: break, no delivery
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h000, 0, 1'b0, -1, 16);
        idle(2);
        @(negedge CLK);
        chk1("brk_busy", busy, 1'b0);
        chk1("brk_valid", rx_if.rx_valid, 1'b0);
        n_cmp++;
        if (brk_cnt != 1) begin
            n_bad++;
            $display("FAIL brk_count: got %0d want 1", brk_cnt);
        end
        @(posedge CLK); #1;
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h03A, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk9("post_brk_data", rx_if.rx_data, 9'h03A);
        @(posedge CLK); #1;

        // Stop bit sampled low on a non-zero word: framing error
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h05A, 0, 1'b0, -1, 0);
        @(negedge CLK);
        chk1("frm_flag", rx_if.frm_err, 1'b1);
        @(posedge CLK); #1;

        // Illegal prescale/length/parity fall back to 8N1 at P=8
        send_frame(6'd12, 4'd3, 2'b11, 1'b0, 9'h0C3, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk9("fallback_data", rx_if.rx_data, 9'h0C3);
        @(posedge CLK); #1;

        // Widest word: 9N1 at P=32
        send_frame(6'd32, 4'd9, 2'b00, 1'b0, 9'h1A5, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk9("w9_data", rx_if.rx_data, 9'h1A5);
        @(posedge CLK); #1;

        // Back-to-back frames with consumer stalled: second frame dropped
        rdy = 1'b0;
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h03C, 0, 1'b1, -1, 0);
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h081, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk1("ovr_pulse", ovr_err, 1'b1);
        chk9("ovr_kept", rx_if.rx_data, 9'h03C);
        chk1("ovr_valid", rx_if.rx_valid, 1'b1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk1("ovr_one_cycle", ovr_err, 1'b0);
        @(posedge CLK); #1;

        // Reset in the middle of a frame while a word is held
        RX_IN = 1'b0;
        idle(10);
        @(negedge CLK);
        chk1("pre_rst_busy", busy, 1'b1);
        #2 RST = 1'b1;
        RX_IN = 1'b1;
        #1;
        chk1("rst2_valid", rx_if.rx_valid, 1'b0);
        chk9("rst2_data", rx_if.rx_data, 9'h000);
        chk1("rst2_busy", busy, 1'b0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0; rdy = 1'b1;
        idle(3);
        send_frame(6'd8, 4'd8, 2'b00, 1'b0, 9'h07E, 0, 1'b1, -1, 0);
        @(negedge CLK);
        chk9("post_rst_data", rx_if.rx_data, 9'h07E);
        chk1("post_rst_valid", rx_if.rx_valid, 1'b1);
        @(posedge CLK); #1;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Parametrised UART receive frame controller, successor to the fixed 8-bit RX FSM. It integrates the bit-timing counters, the 3-sample majority voter and the deserialiser. Data length, parity mode, stop-bit count and oversampling are configured at run time. It adds break detection, overrun detection and a valid/ready output handshake, and sits between the RX input synchroniser and the receive FIFO.

## Interface
- `DATA_W_MAX`, default 9: widest supported frame, in data bits.
- `PRESCALE_W`, default 6: width of the `Prescale` input.
- `CLK` in 1: system clock. All logic is on the rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `RX_IN` in 1: serial line, already synchronised. Idles high.
- `Prescale` in `PRESCALE_W`: oversampling ratio P. Legal values are 8, 16 and 32; any other value is treated as 8.
- `data_len` in 4: data bits per frame. Legal range is 5..`DATA_W_MAX`; any other value is treated as 8.
- `par_mode` in 2: 00 none, 01 even, 10 odd, 11 none.
- `two_stop` in 1: 1 selects two stop bits.
- `rx_ready` in 1: consumer accepts the held frame.
- `rx_data` out `DATA_W_MAX`: received word. LSB is the first bit received. Bits at and above `data_len` are 0.
- `rx_valid` out 1: a frame is held. Stays high until `rx_valid && rx_ready`.
- `par_err` out 1: parity mismatch. Qualified by `rx_valid`.
- `frm_err` out 1: a stop bit was sampled as 0. Qualified by `rx_valid`.
- `brk_det` out 1: one-cycle pulse when a break is detected.
- `ovr_err` out 1: one-cycle pulse when a completed frame is dropped.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BRK_WAIT. Encoding is binary.
- Configuration (`Prescale`, `data_len`, `par_mode`, `two_stop`) is latched on the IDLE->START transition. Changes mid-frame are ignored.
- Edge counter `edge_cnt` runs 0..P-1 within each bit. It wraps to 0 at P-1, and that wrap is the bit boundary.
- Bit counter counts data bits 0..`data_len`-1. A separate stop counter counts 0..1.
- Sampling: `RX_IN` is captured at `edge_cnt` = P/2-1, P/2 and P/2+1. The majority vote is registered and valid at `edge_cnt` = P/2+2.
- IDLE: `RX_IN`==0 moves to START. The detection cycle counts as `edge_cnt`=0.
- START:
  - If the vote is 1 at P/2+2, this is a glitch: go to IDLE with no outputs.
  - Otherwise go to DATA at `edge_cnt`==P-1.
- DATA: at P/2+2 the vote is shifted into bit position `bit_cnt`. At P-1 of the last data bit, go to PARITY if `par_mode` is 01 or 10, else go to STOP.
- PARITY:
  - Even mode: error if XOR(data bits, parity bit) is 1.
  - Odd mode: error if that XOR is 0.
  - Go to STOP at P-1.
- STOP:
  - Any stop vote of 0 sets the frame's `frm_err`.
  - The frame ends at P-1 of the last stop bit, and the state goes to IDLE.
- Break: data bits all 0, parity vote 0 (if enabled) and first stop vote 0.
  - The frame is not delivered.
  - `brk_det` pulses at the first stop's P-1, and the state goes to BRK_WAIT.
  - BRK_WAIT goes to IDLE on the first cycle `RX_IN`==1.
- Delivery at frame end:
  - If `rx_valid` is 0, or `rx_ready` is 1 in the same cycle: load `rx_data`, `par_err` and `frm_err`, and set `rx_valid`.
  - Otherwise the new frame is dropped, the held frame is kept, and `ovr_err` pulses.
- Reset mid-frame returns to IDLE immediately. The partial frame is discarded.

## Timing
- Reset values: every output and every internal register is 0; state is IDLE.
- Frame length: (1 + `data_len` + parity + stops) × P cycles, measured from the detection cycle.
- `rx_valid` rises 1 cycle after the final stop's P-1 cycle, i.e. the first IDLE cycle.
  - Example: 8N1 at P=8, detection at cycle 0 gives `rx_valid`=1 at cycle 80.
- `brk_det` and `ovr_err` are registered pulses of exactly one cycle.
- A new start bit can be detected in the first IDLE cycle after a frame. There is no dead cycle.
- A vote is taken even in the last bit. `edge_cnt` never exceeds P-1.

## Structure
- Shared package `uart_rx_pkg` holds:
  - the state encoding;
  - the `par_mode` constants (PAR_NONE, PAR_EVEN, PAR_ODD);
  - the legal-Prescale constants;
  - default `data_len` = 8.
- One sub-module, `uart_rx_majority_sampler`: a 3-sample capture plus registered vote. Its inputs are `edge_cnt`, P and `RX_IN`; its outputs are `vote` and `vote_vld`.
- The FSM, counters, shift register and output register stay in `uart_rx_frame_ctrl`.

## Test plan
- 8N1, P=8, byte 0xA5, `rx_ready`=1 -> `rx_valid` at cycle 80 with `rx_data`=0x0A5, `par_err`=0, `frm_err`=0.
- 7-bit odd parity, two stops, P=16, data 0x41, wrong parity bit -> `rx_data`=0x41, `par_err`=1; frame is 176 cycles.
- `RX_IN` low for 3 cycles at P=16 -> return to IDLE after the start vote, no `rx_valid`; a following valid frame is received correctly.
- One-cycle high glitch on the middle sample of data bit 3 -> the vote still yields the correct bit, word matches.
- `RX_IN` held low 12 bit-times, 8N1 -> `brk_det` pulses once, no `rx_valid`; next frame after line high is received normally.
- Two frames back to back with `rx_ready`=0 -> first held, `ovr_err` pulse at end of second; `RST` asserted mid-frame -> all outputs 0, `busy`=0 next cycle.
